data_ahb_sram: RTL and testbench
================================

Name: data_ahb_sram

Overview:
- AHB-lite style data-memory responder. It is the slave end of the CPU data bus driven by the core's memory access unit (DATA_H* signals).
- Single-port word-organised SRAM model with byte/halfword/word writes, programmable wait states and a pipelined address/data phase.
- Used as the default data memory in simulation and FPGA builds.

Parameters:
- DEPTH_WORDS, 1024: number of 32-bit words. Must be a power of 2.
- BASE_ADDR, 32'h0000_0000: byte address of word 0.
- WAIT_STATES, 0: HREADY-low cycles inserted in every data phase. Range 0..15.

Ports:
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address (address phase)
- HTRANS  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- HWRITE  in  1  1 = write, 0 = read
- HSIZE  in  3  000 byte, 001 halfword, 010 word
- HBUST  in  3  burst type; accepted and ignored (every beat handled as single)
- HWDATA  in  32  write data (data phase)
- HRDATA  out  32  read data, valid when HREADY=1 in a read data phase
- HREADY  out  1  transfer done / slave ready
- HRESP  out  2  00 OKAY, 01 ERROR

Behaviour:
- Reset: HREADY=1, HRESP=00, HRDATA=0, state IDLE, wait counter 0, any pending transfer discarded. Memory contents are not cleared.
- A transfer is accepted on a rising edge with HSEL=1, HTRANS[1]=1 and HREADY=1. The edge latches addr_q, write_q, size_q.
- IDLE/BUSY or HSEL=0 with HREADY=1: no access, next cycle OKAY with zero wait.
- Word index = (addr_q - BASE_ADDR) >> 2.
- Byte lanes are natural little-endian: byte lane = addr[1:0]; halfword lanes = addr[1]*2 .. +1; word = all four lanes.
- State machine:
  - IDLE: HREADY=1, HRESP=00.
    - Accept with WAIT_STATES>0 -> WAIT, counter=WAIT_STATES.
    - Accept with WAIT_STATES=0 -> DATA.
    - Erroring transfer (feature on) -> ERR1.
  - WAIT: HREADY=0, HRESP=00. Counter decrements each cycle; at 1 -> DATA.
  - DATA: HREADY=1, HRESP=00. Final data-phase cycle; the write commits at the end of this cycle using HWDATA lanes.
    - New accept in this cycle -> WAIT/DATA/ERR1 as from IDLE (back-to-back, no bubble).
    - Otherwise -> IDLE.
  - ERR1: HREADY=0, HRESP=01. Always -> ERR2.
  - ERR2: HREADY=1, HRESP=01. Next state as DATA. No memory write.
- HRDATA is registered. It loads the full word on the edge entering the read's DATA cycle; otherwise it holds its value.
- Write-to-read forwarding: if a write commits on the same edge that loads HRDATA for a read of the same word, the written byte lanes are merged into HRDATA. Back-to-back write then read always returns the new data.
- Reads return the full 32-bit word; the master extracts lanes.
- HSIZE >= 011 is treated as word when the feature is off.
- reset asserted mid-transfer: state goes to IDLE next edge and no write commits in that cycle.

Optional Feature:
- Macro: DATA_SRAM_ERR_RESP_EN.
- Defined: a transfer gets the two-cycle ERROR response (ERR1, ERR2) and no access when any of these holds:
  - misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0;
  - address outside BASE_ADDR .. BASE_ADDR+4*DEPTH_WORDS-1;
  - HSIZE >= 011.
- Undefined: HRESP is constant 00 and ERR states are unreachable. Misaligned addresses are forced to size alignment (low bits cleared). Out-of-range indices wrap modulo DEPTH_WORDS.

Test Plan:
- WAIT_STATES=0: write word 32'hDEADBEEF to 0x10, then read 0x10 back-to-back -> HREADY never low, HRDATA=32'hDEADBEEF in the read data phase (forwarding path).
- Byte write 8'hA5 to 0x13 over a word 32'h11223344 -> read 0x10 returns 32'hA5223344. Halfword 16'hBEEF to 0x12 -> read returns 32'hBEEF3344.
- WAIT_STATES=3: read 0x20 -> HREADY low exactly 3 cycles, then high with data. An IDLE HTRANS in between gives a zero-wait OKAY.
- Feature on: word read at 0x22 -> one cycle HREADY=0/HRESP=01, then HREADY=1/HRESP=01. Word write to 0x22 leaves memory unchanged. Feature off: same write lands at 0x20.
- Assert reset during WAIT of a write to 0x30 -> next cycle HREADY=1, HRESP=00, HRDATA=0, and 0x30 keeps its old value.

Source files
------------

// File: rtl/data_ahb_sram.sv
// AHB-lite data-memory slave: word-organised SRAM with byte/halfword/word writes,
// programmable wait states and optional ERROR responses (DATA_SRAM_ERR_RESP_EN).
module data_ahb_sram #(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic        HWRITE,
    input  logic [2:0]  HSIZE,
    input  logic [2:0]  HBUST,
    input  logic [31:0] HWDATA,
    output logic [31:0] HRDATA,
    output logic        HREADY,
    output logic [1:0]  HRESP
);
    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_WAIT = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_ERR1 = 3'd3;
    localparam logic [2:0] ST_ERR2 = 3'd4;

    logic [2:0]    state, state_nxt;
    logic [3:0]    wait_cnt, wait_cnt_nxt;
    logic [31:0]   addr_q;
    logic          write_q;
    logic [2:0]    size_q;
    logic [31:0]   mem [0:DEPTH_WORDS-1];

    logic          accept;
    logic          req_err;
    logic [32:0]   ap_off;
    logic [31:0]   dp_off;
    logic          wr_en;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] rd_idx;
    logic [3:0]    wr_lanes;
    logic          rd_load;
    logic [31:0]   rd_word;
    logic          unused_bits;

    // Little-endian lanes; misaligned sizes fall onto their aligned lanes.
    function automatic logic [3:0] lane_mask(input logic [1:0] a, input logic [2:0] sz);
        case (sz)
            3'b000:  lane_mask = 4'b0001 << a;
            3'b001:  lane_mask = a[1] ? 4'b1100 : 4'b0011;
            default: lane_mask = 4'b1111;
        endcase
    endfunction

    assign HREADY = (state != ST_WAIT) && (state != ST_ERR1);
    assign accept = HSEL && HTRANS[1] && HREADY;

    // Bit 32 is the borrow: set when the address lies below BASE_ADDR.
    assign ap_off = {1'b0, HADDR} - {1'b0, BASE_ADDR};
    assign dp_off = addr_q - BASE_ADDR;

`ifdef DATA_SRAM_ERR_RESP_EN
    logic misaligned;
    logic out_of_range;
    assign misaligned   = (HSIZE == 3'b001 && HADDR[0]) ||
                          (HSIZE == 3'b010 && HADDR[1:0] != 2'b00);
    assign out_of_range = ap_off[32] || (ap_off[31:AW+2] != '0);
    assign req_err      = misaligned || out_of_range || (HSIZE > 3'b010);
    assign HRESP        = (state == ST_ERR1 || state == ST_ERR2) ? 2'b01 : 2'b00;
`else
    assign req_err = 1'b0;
    assign HRESP   = 2'b00;
`endif

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        case (state)
            ST_WAIT: begin
                wait_cnt_nxt = wait_cnt - 4'd1;
                if (wait_cnt == 4'd1) state_nxt = ST_DATA;
            end
            ST_ERR1: state_nxt = ST_ERR2;
            default: begin
                // IDLE, DATA and ERR2 all have HREADY high and may accept back-to-back.
                if (!accept) begin
                    state_nxt = ST_IDLE;
                end else if (req_err) begin
                    state_nxt = ST_ERR1;
                end else if (WAIT_STATES > 0) begin
                    state_nxt    = ST_WAIT;
                    wait_cnt_nxt = WAIT_INIT;
                end else begin
                    state_nxt = ST_DATA;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            wait_cnt <= 4'd0;
            addr_q   <= 32'd0;
            write_q  <= 1'b0;
            size_q   <= 3'd0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            if (accept) begin
                addr_q  <= HADDR;
                write_q <= HWRITE;
                size_q  <= HSIZE;
            end
        end
    end

    assign wr_en    = (state == ST_DATA) && write_q && !reset;
    assign wr_idx   = dp_off[AW+1:2];
    assign wr_lanes = lane_mask(addr_q[1:0], size_q);

    // With zero wait states the read word is fetched from the address phase directly.
    assign rd_idx  = (state == ST_WAIT) ? dp_off[AW+1:2] : ap_off[AW+1:2];
    assign rd_load = (accept && !req_err && !HWRITE && WAIT_STATES == 0) ||
                     (state == ST_WAIT && wait_cnt == 4'd1 && !write_q);

    always_comb begin
        rd_word = mem[rd_idx];
        for (int i = 0; i < 4; i++) begin
            if (wr_en && wr_idx == rd_idx && wr_lanes[i])
                rd_word[8*i +: 8] = HWDATA[8*i +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (reset)        HRDATA <= 32'd0;
        else if (rd_load) HRDATA <= rd_word;
    end

    // NOTE: the memory array has no reset; contents survive reset like a real SRAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_lanes[i]) mem[wr_idx][8*i +: 8] <= HWDATA[8*i +: 8];
            end
        end
    end

    assign unused_bits = ^{HBUST, HTRANS[0], ap_off[32], ap_off[31:AW+2], ap_off[1:0],
                           dp_off[31:AW+2], dp_off[1:0]};

endmodule

// File: tb/tb_data_ahb_sram.sv
// Self-checking bench for data_ahb_sram: directed vector table, reset corner cases,
// and randomized pipelined traffic against a word-array reference model.
module tb_data_ahb_sram;
    localparam int DEPTH = 64;
`ifdef DATA_SRAM_ERR_RESP_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        hsel0, hsel1;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic [2:0]  hburst;
    logic [31:0] hwdata;
    logic [31:0] hrdata0, hrdata1;
    logic        hready0, hready1;
    logic [1:0]  hresp0, hresp1;

    int checks = 0;
    int errors = 0;
    logic [31:0] model [2][DEPTH];

    typedef struct {
        int          d;
        bit          w;
        logic [31:0] addr;
        logic [2:0]  sz;
        logic [31:0] wdata;
        int          waits;
        logic [1:0]  resp;
        bit          chk_rd;
        logic [31:0] rd;
    } vec_t;

    typedef struct {
        bit          valid;
        bit          w;
        bit          err;
        logic [31:0] a;
        logic [2:0]  sz;
        logic [31:0] wd;
    } xfer_t;

    data_ahb_sram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .reset(reset), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBUST(hburst), .HWDATA(hwdata),
        .HRDATA(hrdata0), .HREADY(hready0), .HRESP(hresp0)
    );

    data_ahb_sram #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .reset(reset), .HSEL(hsel1), .HADDR(haddr), .HTRANS(htrans),
        .HWRITE(hwrite), .HSIZE(hsize), .HBUST(hburst), .HWDATA(hwdata),
        .HRDATA(hrdata1), .HREADY(hready1), .HRESP(hresp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    function automatic logic get_ready(input int d);
        return (d == 0) ? hready0 : hready1;
    endfunction
    function automatic logic [1:0] get_resp(input int d);
        return (d == 0) ? hresp0 : hresp1;
    endfunction
    function automatic logic [31:0] get_rdata(input int d);
        return (d == 0) ? hrdata0 : hrdata1;
    endfunction
    function automatic int wait_states(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    // Reference rules: word index modulo depth, byte b written when it falls inside the sized access.
    function automatic int midx(input logic [31:0] a);
        return int'((a / 4) % DEPTH);
    endfunction
    function automatic bit byte_hit(input logic [31:0] a, input logic [2:0] sz, input int b);
        if (sz == 3'd0) return b == int'(a % 4);
        if (sz == 3'd1) return (b / 2) == int'((a % 4) / 2);
        return 1'b1;
    endfunction
    function automatic bit exp_err(input logic [31:0] a, input logic [2:0] sz);
        bit bad_align = (sz == 3'd1 && (a % 2) != 0) || (sz == 3'd2 && (a % 4) != 0);
        return ERR_EN && (sz > 3'd2 || bad_align || a >= 32'(4 * DEPTH));
    endfunction

    task automatic model_write(input int d, input logic [31:0] a, input logic [2:0] sz,
                               input logic [31:0] wd);
        int i = midx(a);
        for (int b = 0; b < 4; b++)
            if (byte_hit(a, sz, b)) model[d][i][8*b +: 8] = wd[8*b +: 8];
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic set_bus(input int d, input logic sel, input logic [1:0] trans,
                           input logic [31:0] a, input logic w, input logic [2:0] sz);
        hsel0  = (d == 0) && sel;
        hsel1  = (d == 1) && sel;
        htrans = trans;
        haddr  = a;
        hwrite = w;
        hsize  = sz;
        hburst = 3'($urandom_range(0, 7));
    endtask

    task automatic bus_idle();
        hsel0  = 1'b0;
        hsel1  = 1'b0;
        htrans = 2'b00;
    endtask

    // One isolated transfer: address phase, then data phase until HREADY.
    task automatic do_xfer(input int d, input bit w, input logic [31:0] a, input logic [2:0] sz,
                           input logic [31:0] wd, output logic [31:0] rd, output int waits,
                           output logic [1:0] resp_first, output logic [1:0] resp_last,
                           output bit timeout);
        @(negedge clk);
        set_bus(d, 1'b1, 2'b10, a, w, sz);
        @(negedge clk);
        bus_idle();
        hwdata     = wd;
        waits      = 0;
        resp_first = get_resp(d);
        while (!get_ready(d) && waits < 50) begin
            waits++;
            @(negedge clk);
        end
        timeout   = !get_ready(d);
        rd        = get_rdata(d);
        resp_last = get_resp(d);
    endtask

    function automatic vec_t mk(input int d, input bit w, input logic [31:0] a, input logic [2:0] sz,
                                input logic [31:0] wd, input int waits, input logic [1:0] resp,
                                input bit chk_rd, input logic [31:0] rd);
        vec_t v;
        v.d = d; v.w = w; v.addr = a; v.sz = sz; v.wdata = wd;
        v.waits = waits; v.resp = resp; v.chk_rd = chk_rd; v.rd = rd;
        return v;
    endfunction

    task automatic run_random(input int d, input int n);
        xfer_t       ap, dp;
        bit          ap_live = 1'b0;
        int          issued = 0;
        int          budget = 0;
        int          waits = 0;
        logic        r;
        logic [1:0]  resp;
        logic [31:0] last_a = 32'h0;
        int          k;
        dp.valid = 1'b0;
        ap.valid = 1'b0;
        while ((issued < n || dp.valid || ap_live) && budget < 20000) begin
            @(negedge clk);
            budget++;
            if (ap_live) begin
                dp       = ap;
                dp.valid = 1'b1;
                hwdata   = ap.wd;
                waits    = 0;
                ap_live  = 1'b0;
            end
            r    = get_ready(d);
            resp = get_resp(d);
            if (dp.valid) begin
                check("rnd_resp", 32'(resp), dp.err ? 32'd1 : 32'd0);
                if (!r) begin
                    waits++;
                end else begin
                    check("rnd_waits", 32'(waits), dp.err ? 32'd1 : 32'(wait_states(d)));
                    if (!dp.err) begin
                        if (dp.w) model_write(d, dp.a, dp.sz, dp.wd);
                        else      check("rnd_rdata", get_rdata(d), model[d][midx(dp.a)]);
                    end
                    dp.valid = 1'b0;
                end
            end else begin
                check("rnd_idle_ready", 32'(r), 32'd1);
                check("rnd_idle_resp", 32'(resp), 32'd0);
            end
            if (r) begin
                k = (issued < n) ? $urandom_range(0, 9) : 0;
                if (k == 0)      set_bus(d, 1'b1, 2'b00, 32'($urandom), 1'b0, 3'd2);
                else if (k == 1) set_bus(d, 1'b1, 2'b01, 32'($urandom), 1'b1, 3'd2);
                else if (k == 2) set_bus(d, 1'b0, 2'b10, 32'($urandom), 1'b1, 3'd2);
                else begin
                    ap.a  = ($urandom_range(0, 2) == 0) ? last_a : 32'($urandom_range(0, 'h13F));
                    ap.sz = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7))
                                                        : 3'($urandom_range(0, 2));
                    if ($urandom_range(0, 1) == 1 && ap.sz == 3'd1) ap.a = ap.a & ~32'd1;
                    if ($urandom_range(0, 1) == 1 && ap.sz == 3'd2) ap.a = ap.a & ~32'd3;
                    ap.w   = 1'($urandom_range(0, 1));
                    ap.wd  = $urandom;
                    ap.err = exp_err(ap.a, ap.sz);
                    last_a = ap.a;
                    set_bus(d, 1'b1, 2'($urandom_range(2, 3)), ap.a, ap.w, ap.sz);
                    ap_live = 1'b1;
                    issued++;
                end
            end
        end
        check("rnd_budget", 32'(budget < 20000), 32'd1);
        @(negedge clk);
        bus_idle();
    endtask

    initial begin
        vec_t        tbl[$];
        logic [31:0] rd;
        int          waits;
        logic [1:0]  rf, rl;
        bit          to;

        reset  = 1'b1;
        hwdata = 32'h0;
        haddr  = 32'h0;
        hwrite = 1'b0;
        hsize  = 3'd0;
        hburst = 3'd0;
        bus_idle();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        check("rst_ready0", 32'(hready0), 32'd1);
        check("rst_resp0",  32'(hresp0),  32'd0);
        check("rst_rdata0", hrdata0, 32'h0);
        check("rst_ready1", 32'(hready1), 32'd1);
        check("rst_resp1",  32'(hresp1),  32'd0);
        check("rst_rdata1", hrdata1, 32'h0);

        // Back-to-back write then read with zero wait states exercises forwarding.
        @(negedge clk);
        set_bus(0, 1'b1, 2'b10, 32'h10, 1'b1, 3'd2);
        @(negedge clk);
        check("b2b_wr_ready", 32'(hready0), 32'd1);
        hwdata = 32'hDEADBEEF;
        set_bus(0, 1'b1, 2'b10, 32'h10, 1'b0, 3'd2);
        @(negedge clk);
        check("b2b_rd_ready", 32'(hready0), 32'd1);
        check("b2b_rd_data", hrdata0, 32'hDEADBEEF);
        bus_idle();

        tbl.push_back(mk(1, 1, 32'h10, 3'd2, 32'h11223344, 3, 2'b00, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h10, 3'd2, 32'h0,        3, 2'b00, 1, 32'h11223344));
        tbl.push_back(mk(1, 1, 32'h13, 3'd0, 32'hA5A5A5A5, 3, 2'b00, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h10, 3'd2, 32'h0,        3, 2'b00, 1, 32'hA5223344));
        tbl.push_back(mk(1, 1, 32'h12, 3'd1, 32'hBEEFBEEF, 3, 2'b00, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h10, 3'd2, 32'h0,        3, 2'b00, 1, 32'hBEEF3344));
        tbl.push_back(mk(1, 1, 32'h20, 3'd2, 32'hCAFEF00D, 3, 2'b00, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h20, 3'd2, 32'h0,        3, 2'b00, 1, 32'hCAFEF00D));
        tbl.push_back(mk(1, 1, 32'h22, 3'd2, 32'h12345678, ERR_EN ? 1 : 3,
                         ERR_EN ? 2'b01 : 2'b00, 0, 32'h0));
        tbl.push_back(mk(1, 0, 32'h20, 3'd2, 32'h0, 3, 2'b00, 1,
                         ERR_EN ? 32'hCAFEF00D : 32'h12345678));
        tbl.push_back(mk(1, 0, 32'h22, 3'd2, 32'h0, ERR_EN ? 1 : 3,
                         ERR_EN ? 2'b01 : 2'b00, !ERR_EN, 32'h12345678));
        tbl.push_back(mk(0, 1, 32'h04, 3'd2, 32'h01020304, 0, 2'b00, 0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h05, 3'd0, 32'h77777777, 0, 2'b00, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h04, 3'd2, 32'h0,        0, 2'b00, 1, 32'h01027704));
        tbl.push_back(mk(0, 1, 32'h07, 3'd1, 32'h99999999, ERR_EN ? 1 : 0,
                         ERR_EN ? 2'b01 : 2'b00, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h04, 3'd2, 32'h0, 0, 2'b00, 1,
                         ERR_EN ? 32'h01027704 : 32'h99997704));
        tbl.push_back(mk(0, 0, 32'h104, 3'd2, 32'h0, ERR_EN ? 1 : 0,
                         ERR_EN ? 2'b01 : 2'b00, !ERR_EN, 32'h99997704));
        tbl.push_back(mk(0, 0, 32'h04, 3'd3, 32'h0, ERR_EN ? 1 : 0,
                         ERR_EN ? 2'b01 : 2'b00, !ERR_EN, 32'h99997704));
        tbl.push_back(mk(0, 1, 32'h08, 3'd2, 32'hAAAA5555, 0, 2'b00, 0, 32'h0));
        tbl.push_back(mk(0, 1, 32'h108, 3'd2, 32'h0F0F0F0F, ERR_EN ? 1 : 0,
                         ERR_EN ? 2'b01 : 2'b00, 0, 32'h0));
        tbl.push_back(mk(0, 0, 32'h08, 3'd2, 32'h0, 0, 2'b00, 1,
                         ERR_EN ? 32'hAAAA5555 : 32'h0F0F0F0F));

        for (int i = 0; i < tbl.size(); i++) begin
            do_xfer(tbl[i].d, tbl[i].w, tbl[i].addr, tbl[i].sz, tbl[i].wdata, rd, waits, rf, rl, to);
            check($sformatf("tbl%0d_timeout", i), 32'(to), 32'd0);
            check($sformatf("tbl%0d_waits", i), 32'(waits), 32'(tbl[i].waits));
            check($sformatf("tbl%0d_resp_first", i), 32'(rf), 32'(tbl[i].resp));
            check($sformatf("tbl%0d_resp_last", i), 32'(rl), 32'(tbl[i].resp));
            if (tbl[i].chk_rd) check($sformatf("tbl%0d_rdata", i), rd, tbl[i].rd);
        end

        // Reset during the WAIT phase of a write: no commit, outputs return to reset values.
        do_xfer(1, 1'b1, 32'h30, 3'd2, 32'h0BAD0030, rd, waits, rf, rl, to);
        do_xfer(1, 1'b0, 32'h30, 3'd2, 32'h0, rd, waits, rf, rl, to);
        check("rstw_pre_rdata", rd, 32'h0BAD0030);
        @(negedge clk);
        set_bus(1, 1'b1, 2'b10, 32'h30, 1'b1, 3'd2);
        @(negedge clk);
        bus_idle();
        hwdata = 32'hFFFFFFFF;
        check("rstw_in_wait", 32'(hready1), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstw_ready", 32'(hready1), 32'd1);
        check("rstw_resp",  32'(hresp1),  32'd0);
        check("rstw_rdata", hrdata1, 32'h0);
        do_xfer(1, 1'b0, 32'h30, 3'd2, 32'h0, rd, waits, rf, rl, to);
        check("rstw_mem_kept", rd, 32'h0BAD0030);

        // Reset in the final DATA cycle of a zero-wait write also blocks the commit.
        do_xfer(0, 1'b1, 32'h34, 3'd2, 32'h55AA55AA, rd, waits, rf, rl, to);
        @(negedge clk);
        set_bus(0, 1'b1, 2'b10, 32'h34, 1'b1, 3'd2);
        @(negedge clk);
        bus_idle();
        hwdata = 32'h0;
        reset  = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("rstd_ready", 32'(hready0), 32'd1);
        do_xfer(0, 1'b0, 32'h34, 3'd2, 32'h0, rd, waits, rf, rl, to);
        check("rstd_mem_kept", rd, 32'h55AA55AA);

        // Fill both memories with known words before random traffic.
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < DEPTH; i++) begin
                model[d][i] = $urandom;
                do_xfer(d, 1'b1, 32'(4 * i), 3'd2, model[d][i], rd, waits, rf, rl, to);
            end
        end

        run_random(0, 400);
        run_random(1, 400);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
